axi_aw_decoder_remap: RTL and testbench

// - Next-gen AW-channel address decoder for the AXI node: one target port per AW, plus a decode-error path.
// - Sits between a master's AW slave port and the N_INIT_PORT initiator request blocks.
// - Adds over the previous generation: one-hot priority select, internal outstanding counter, captured error ID, optional runtime port remap.

---
 rtl/axi_aw_dec_pkg.sv | 20 ++
 rtl/axi_aw_region_match.sv | 39 +++
 rtl/axi_aw_decoder_remap.sv | 189 ++++++++++++++++++
 tb/tb_axi_aw_decoder_remap.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_aw_dec_pkg.sv
// Shared types and helpers for the AW-channel address decoder.
package axi_aw_dec_pkg;

    // Widest port vector lowest_onehot() can handle; callers cast in and out.
    localparam int unsigned ONEHOT_MAX_W = 32;

    // Decoder control states: normal routing, then the three steps of a decode-error burst.
    typedef enum logic [1:0] {
        OPERATIVE    = 2'd0,
        DRAIN        = 2'd1,
        ACCEPT_WDATA = 2'd2,
        ERROR_RESP   = 2'd3
    } aw_dec_state_e;

    // Keep only the lowest set bit, so overlapping hits can never become multi-hot.
    function automatic logic [ONEHOT_MAX_W-1:0] lowest_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
        lowest_onehot = vec & (~vec + ONEHOT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/axi_aw_region_match.sv
// Per-port address range compare. Region slot s = r*N_INIT_PORT + p; each slot
// holds an inclusive unsigned [start, end] window and an enable bit.
module axi_aw_region_match #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned N_INIT_PORT = 8,
    parameter int unsigned N_REGION    = 2
) (
    input  logic [ADDR_WIDTH-1:0]                      addr,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr,
    input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region,
    output logic [N_INIT_PORT-1:0]                     hit
);

    localparam int unsigned N_SLOT = N_REGION * N_INIT_PORT;

    logic [N_SLOT-1:0] slot_hit;

    // Inclusive window compare for every region slot.
    always_comb begin
        slot_hit = '0;
        for (int unsigned s = 0; s < N_SLOT; s++) begin
            slot_hit[s] = enable_region[s]
                       && (addr >= start_addr[s*ADDR_WIDTH +: ADDR_WIDTH])
                       && (addr <= end_addr[s*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // A port hits when any of its regions hits.
    always_comb begin
        hit = '0;
        for (int unsigned r = 0; r < N_REGION; r++) begin
            for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
                hit[p] = hit[p] | slot_hit[r*N_INIT_PORT + p];
            end
        end
    end

endmodule

// File: rtl/axi_aw_decoder_remap.sv
// AW-channel address decoder: routes each AW to one initiator port (one-hot,
// lowest index wins), tracks outstanding writes and runs the decode-error
// sequence (drain, absorb W burst, DECERR B response).
// Optional feature: define AXI_AW_DEC_REMAP_EN to add the remap_i port, which
// maps each matched logical port to a physical port at runtime.
module axi_aw_decoder_remap
    import axi_aw_dec_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned N_INIT_PORT     = 8,
    parameter int unsigned LOG_N_INIT      = 3,
    parameter int unsigned N_REGION        = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       awvalid_i,
    input  logic [ADDR_WIDTH-1:0]                      awaddr_i,
    input  logic [ID_WIDTH-1:0]                        awid_i,
    output logic                                       awready_o,
    output logic [N_INIT_PORT-1:0]                     awvalid_o,
    input  logic [N_INIT_PORT-1:0]                     awready_i,
    input  logic                                       grant_fifo_dest_i,
    output logic [N_INIT_PORT-1:0]                     dest_o,
    output logic                                       push_dest_o,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
    input  logic [N_INIT_PORT-1:0]                     connectivity_map_i,
`ifdef AXI_AW_DEC_REMAP_EN
    input  logic [N_INIT_PORT*LOG_N_INIT-1:0]          remap_i,
`endif
    input  logic                                       b_done_i,
    output logic                                       handle_error_o,
    input  logic                                       wdata_error_completed_i,
    output logic                                       error_req_o,
    output logic [ID_WIDTH-1:0]                        error_id_o,
    input  logic                                       error_gnt_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [N_INIT_PORT-1:0] hit;
    logic [N_INIT_PORT-1:0] port_ok;
    logic [N_INIT_PORT-1:0] win_log;
    logic [N_INIT_PORT-1:0] sel;
    logic                   dec_err;
    logic [LOG_N_INIT-1:0]  phys_map [N_INIT_PORT];

    aw_dec_state_e          state_q;
    aw_dec_state_e          state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_after_b;
    logic                   cnt_dec;
    logic                   can_issue;
    logic                   err_capture;
    logic [ID_WIDTH-1:0]    err_id_q;

    axi_aw_region_match #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .N_INIT_PORT (N_INIT_PORT),
        .N_REGION    (N_REGION)
    ) u_region_match (
        .addr          (awaddr_i),
        .start_addr    (start_addr_i),
        .end_addr      (end_addr_i),
        .enable_region (enable_region_i),
        .hit           (hit)
    );

    // Logical-to-physical port map: runtime table or identity.
    always_comb begin
        for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
`ifdef AXI_AW_DEC_REMAP_EN
            phys_map[p] = remap_i[p*LOG_N_INIT +: LOG_N_INIT];
`else
            phys_map[p] = LOG_N_INIT'(p);
`endif
        end
    end

    // A logical hit is usable only if its physical port exists and is reachable.
    always_comb begin
        port_ok = '0;
        for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
            port_ok[p] = hit[p]
                      && (32'(phys_map[p]) < N_INIT_PORT)
                      && connectivity_map_i[phys_map[p]];
        end
    end

    // Lowest usable logical port wins; translate the winner to a physical one-hot.
    always_comb begin
        win_log = N_INIT_PORT'(lowest_onehot(ONEHOT_MAX_W'(port_ok)));
        sel     = '0;
        for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
            if (win_log[p]) begin
                sel[phys_map[p]] = 1'b1;
            end
        end
        dec_err = ~|port_ok;
    end

    // Counter helpers; DRAIN exits on the edge where the counter reaches zero.
    always_comb begin
        cnt_dec     = b_done_i && (cnt_q != '0);
        cnt_after_b = cnt_q - CNT_W'(cnt_dec);
        can_issue   = grant_fifo_dest_i && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    end

    // Next-state and outputs; the stall condition also holds back error AWs.
    always_comb begin
        state_d        = state_q;
        awready_o      = 1'b0;
        awvalid_o      = '0;
        dest_o         = '0;
        push_dest_o    = 1'b0;
        handle_error_o = 1'b0;
        error_req_o    = 1'b0;
        error_id_o     = '0;
        err_capture    = 1'b0;

        if (!rst) begin
            unique case (state_q)
                OPERATIVE: begin
                    if (can_issue) begin
                        if (!dec_err) begin
                            awvalid_o   = sel & {N_INIT_PORT{awvalid_i}};
                            awready_o   = |(sel & awready_i);
                            dest_o      = sel;
                            push_dest_o = awvalid_i & awready_o;
                        end else if (awvalid_i) begin
                            awready_o   = 1'b1;
                            err_capture = 1'b1;
                            state_d     = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_after_b == '0) begin
                        state_d = ACCEPT_WDATA;
                    end
                end
                ACCEPT_WDATA: begin
                    handle_error_o = 1'b1;
                    if (wdata_error_completed_i) begin
                        state_d = ERROR_RESP;
                    end
                end
                ERROR_RESP: begin
                    error_req_o = 1'b1;
                    error_id_o  = err_id_q;
                    if (error_gnt_i) begin
                        state_d = OPERATIVE;
                    end
                end
                default: state_d = OPERATIVE;
            endcase
        end
    end

    // Outstanding count: +1 per port handshake, -1 per B, simultaneous cancels.
    always_comb begin
        cnt_d = cnt_q;
        if (push_dest_o && !cnt_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_dest_o && cnt_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State, counter and captured error ID registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OPERATIVE;
            cnt_q    <= '0;
            err_id_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_capture) begin
                err_id_q <= awid_i;
            end
        end
    end

endmodule

// File: tb/tb_axi_aw_decoder_remap.sv
// Bench for axi_aw_decoder_remap: directed scenarios followed by random
// traffic, all checked against a behavioural model of the decoder.
module tb_axi_aw_decoder_remap;

    localparam int unsigned AW   = 32;
    localparam int unsigned IW   = 4;
    localparam int unsigned NP   = 8;
    localparam int unsigned LG   = 3;
    localparam int unsigned NR   = 2;
    localparam int unsigned MAXO = 2;

    localparam int unsigned PH_OP   = 0;
    localparam int unsigned PH_DRN  = 1;
    localparam int unsigned PH_WD   = 2;
    localparam int unsigned PH_RESP = 3;

    logic              clk;
    logic              rst;
    logic              awvalid_i;
    logic [AW-1:0]     awaddr_i;
    logic [IW-1:0]     awid_i;
    logic              awready_o;
    logic [NP-1:0]     awvalid_o;
    logic [NP-1:0]     awready_i;
    logic              grant_fifo_dest_i;
    logic [NP-1:0]     dest_o;
    logic              push_dest_o;
    logic [NR*NP*AW-1:0] start_addr_i;
    logic [NR*NP*AW-1:0] end_addr_i;
    logic [NR*NP-1:0]  enable_region_i;
    logic [NP-1:0]     connectivity_map_i;
    logic              b_done_i;
    logic              handle_error_o;
    logic              wdata_error_completed_i;
    logic              error_req_o;
    logic [IW-1:0]     error_id_o;
    logic              error_gnt_i;

    logic [AW-1:0]     rs  [NR][NP];
    logic [AW-1:0]     re  [NR][NP];
    logic              ren [NR][NP];
    int unsigned       remap_tab [NP];

    int unsigned       n_chk;
    int unsigned       n_bad;
    int unsigned       m_phase, m_cnt, n_phase, n_cnt;
    logic [IW-1:0]     m_id, n_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < NP; p++) begin
                start_addr_i[(r*NP+p)*AW +: AW] = rs[r][p];
                end_addr_i[(r*NP+p)*AW +: AW]   = re[r][p];
                enable_region_i[r*NP+p]         = ren[r][p];
            end
        end
    end

`ifdef AXI_AW_DEC_REMAP_EN
    logic [NP*LG-1:0] remap_i;
    always_comb begin
        for (int p = 0; p < NP; p++) remap_i[p*LG +: LG] = LG'(remap_tab[p]);
    end
`endif

    axi_aw_decoder_remap #(
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IW),
        .N_INIT_PORT     (NP),
        .LOG_N_INIT      (LG),
        .N_REGION        (NR),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .awvalid_i               (awvalid_i),
        .awaddr_i                (awaddr_i),
        .awid_i                  (awid_i),
        .awready_o               (awready_o),
        .awvalid_o               (awvalid_o),
        .awready_i               (awready_i),
        .grant_fifo_dest_i       (grant_fifo_dest_i),
        .dest_o                  (dest_o),
        .push_dest_o             (push_dest_o),
        .start_addr_i            (start_addr_i),
        .end_addr_i              (end_addr_i),
        .enable_region_i         (enable_region_i),
        .connectivity_map_i      (connectivity_map_i),
`ifdef AXI_AW_DEC_REMAP_EN
        .remap_i                 (remap_i),
`endif
        .b_done_i                (b_done_i),
        .handle_error_o          (handle_error_o),
        .wdata_error_completed_i (wdata_error_completed_i),
        .error_req_o             (error_req_o),
        .error_id_o              (error_id_o),
        .error_gnt_i             (error_gnt_i)
    );

    // A B response with nothing outstanding is a stimulus bug.
    always @(negedge clk) begin
        assert (rst || !b_done_i || m_cnt != 0)
            else $error("b_done_i issued with no write outstanding");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Route an address: first logical port (by index) with an enabled
    // inclusive window, a real physical target and connectivity.
    function automatic logic [NP-1:0] m_route(input logic [AW-1:0] a, output logic is_err);
        logic [NP-1:0] route;
        route  = '0;
        is_err = 1'b1;
        for (int p = 0; p < NP; p++) begin
            bit h = 0;
            int unsigned ph = remap_tab[p];
            for (int r = 0; r < NR; r++)
                if (ren[r][p] && a >= rs[r][p] && a <= re[r][p]) h = 1;
            if (h && is_err && ph < NP && connectivity_map_i[ph]) begin
                route  = NP'(1 << ph);
                is_err = 1'b0;
            end
        end
        return route;
    endfunction

    // Compare all outputs with the model at the negedge and compute the model's next state.
    task automatic settle();
        logic [NP-1:0] route, e_awv, e_dest;
        logic          is_err, e_awr, e_push, e_he, e_req;
        logic [IW-1:0] e_id;
        int unsigned   dec, hs;
        @(negedge clk);
        route  = m_route(awaddr_i, is_err);
        e_awv  = '0; e_dest = '0; e_awr = 1'b0; e_push = 1'b0;
        e_he   = 1'b0; e_req = 1'b0; e_id = '0;
        n_phase = m_phase; n_id = m_id;
        hs  = 0;
        dec = (b_done_i && m_cnt > 0) ? 1 : 0;
        if (rst) begin
            n_phase = PH_OP; n_cnt = 0; n_id = '0;
        end else begin
            case (m_phase)
                PH_OP: begin
                    if (grant_fifo_dest_i && m_cnt < MAXO) begin
                        if (!is_err) begin
                            e_awv  = awvalid_i ? route : '0;
                            e_awr  = |(route & awready_i);
                            e_dest = route;
                            e_push = awvalid_i && e_awr;
                            hs     = e_push ? 1 : 0;
                        end else if (awvalid_i) begin
                            e_awr   = 1'b1;
                            n_id    = awid_i;
                            n_phase = PH_DRN;
                        end
                    end
                end
                PH_DRN: if (m_cnt - dec == 0) n_phase = PH_WD;
                PH_WD: begin
                    e_he = 1'b1;
                    if (wdata_error_completed_i) n_phase = PH_RESP;
                end
                default: begin
                    e_req = 1'b1;
                    e_id  = m_id;
                    if (error_gnt_i) n_phase = PH_OP;
                end
            endcase
            n_cnt = m_cnt + hs - dec;
        end
        chk("awvalid_o",      32'(awvalid_o),      32'(e_awv));
        chk("awready_o",      32'(awready_o),      32'(e_awr));
        chk("dest_o",         32'(dest_o),         32'(e_dest));
        chk("push_dest_o",    32'(push_dest_o),    32'(e_push));
        chk("handle_error_o", 32'(handle_error_o), 32'(e_he));
        chk("error_req_o",    32'(error_req_o),    32'(e_req));
        chk("error_id_o",     32'(error_id_o),     32'(e_id));
    endtask

    task automatic tick();
        @(posedge clk);
        m_phase = n_phase; m_cnt = n_cnt; m_id = n_id;
        #1;
    endtask

    task automatic set_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [NP-1:0] rdy);
        awvalid_i = 1'b1; awaddr_i = a; awid_i = id; awready_i = rdy;
    endtask

    task automatic clear_cfg();
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < NP; p++) begin
                rs[r][p] = '0; re[r][p] = '0; ren[r][p] = 1'b0;
            end
        for (int p = 0; p < NP; p++) remap_tab[p] = p;
        connectivity_map_i = '1;
    endtask

    task automatic random_cfg();
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < NP; p++) begin
                rs[r][p]  = AW'($urandom_range(0, 32'hF000));
                re[r][p]  = ($urandom_range(0, 9) == 0) ? rs[r][p] - AW'(1)
                                                        : rs[r][p] + AW'($urandom_range(0, 32'h1FFF));
                ren[r][p] = ($urandom_range(0, 3) != 0);
            end
        connectivity_map_i = NP'($urandom) | NP'($urandom);
`ifdef AXI_AW_DEC_REMAP_EN
        for (int p = 0; p < NP; p++) remap_tab[p] = $urandom_range(0, NP-1);
`endif
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r = $urandom_range(0, NR-1);
        int unsigned p = $urandom_range(0, NP-1);
        case ($urandom_range(0, 5))
            0:       return AW'($urandom);
            1:       return rs[r][p];
            2:       return re[r][p];
            3:       return rs[r][p] - AW'(1);
            4:       return re[r][p] + AW'(1);
            default: return AW'($urandom_range(0, 32'h11000));
        endcase
    endfunction

    initial begin
        n_chk = 0; n_bad = 0;
        m_phase = PH_OP; m_cnt = 0; m_id = '0;
        n_phase = PH_OP; n_cnt = 0; n_id = '0;
        rst = 1'b1; awvalid_i = 1'b0; awaddr_i = '0; awid_i = '0; awready_i = '0;
        grant_fifo_dest_i = 1'b1; b_done_i = 1'b0;
        wdata_error_completed_i = 1'b0; error_gnt_i = 1'b0;
        clear_cfg();
        rs[0][2] = 32'h1000; re[0][2] = 32'h1FFF; ren[0][2] = 1'b1;
        rs[0][1] = 32'h4000; re[0][1] = 32'h4FFF; ren[0][1] = 1'b1;
        rs[1][3] = 32'h3000; re[1][3] = 32'h40FF; ren[1][3] = 1'b1;

        // Reset with a pending AW: outputs stay quiet.
        set_aw(32'h1FFF, 4'h3, 8'hFF);
        settle(); chk("rst_awvalid", 32'(awvalid_o), 32'h0); chk("rst_awready", 32'(awready_o), 32'h0); tick();
        settle(); tick();
        rst = 1'b0;

        // Upper boundary of port 2's window.
        set_aw(32'h1FFF, 4'h3, 8'h04);
        settle(); chk("p2_awvalid", 32'(awvalid_o), 32'h04); chk("p2_dest", 32'(dest_o), 32'h04);
        chk("p2_push", 32'(push_dest_o), 32'h1); tick();
        // Overlapping ports 1 and 3: only port 1.
        set_aw(32'h4000, 4'h1, 8'h0A);
        settle(); chk("ovl_awvalid", 32'(awvalid_o), 32'h02); chk("ovl_push", 32'(push_dest_o), 32'h1); tick();
        // Counter at the cap: third AW held.
        set_aw(32'h1000, 4'h2, 8'h04);
        settle(); chk("cap_awready", 32'(awready_o), 32'h0); chk("cap_awvalid", 32'(awvalid_o), 32'h0); tick();
        b_done_i = 1'b1;
        settle(); chk("cap_b_awready", 32'(awready_o), 32'h0); tick();
        b_done_i = 1'b0;
        settle(); chk("after_b_push", 32'(push_dest_o), 32'h1); tick();
        awvalid_i = 1'b0; b_done_i = 1'b1;
        settle(); tick();
        awvalid_i = 1'b1;
        settle(); chk("both_push", 32'(push_dest_o), 32'h1); tick();
        b_done_i = 1'b0;
        settle(); chk("one_left_push", 32'(push_dest_o), 32'h1); tick();
        settle(); chk("full_again_awready", 32'(awready_o), 32'h0); tick();
        awvalid_i = 1'b0; b_done_i = 1'b1;
        settle(); tick();
        b_done_i = 1'b0;

        // Decode error with one write still outstanding.
        set_aw(32'hF000_0000, 4'h5, 8'hFF);
        settle(); chk("err_awready", 32'(awready_o), 32'h1); chk("err_awvalid", 32'(awvalid_o), 32'h0);
        chk("err_push", 32'(push_dest_o), 32'h0); tick();
        awvalid_i = 1'b0;
        settle(); chk("drain_he", 32'(handle_error_o), 32'h0); tick();
        b_done_i = 1'b1;
        settle(); tick();
        b_done_i = 1'b0;
        settle(); chk("wd_he", 32'(handle_error_o), 32'h1); tick();
        wdata_error_completed_i = 1'b1;
        settle(); tick();
        wdata_error_completed_i = 1'b0;
        settle(); chk("resp_req", 32'(error_req_o), 32'h1); chk("resp_id", 32'(error_id_o), 32'h5); tick();
        error_gnt_i = 1'b1;
        settle(); tick();
        error_gnt_i = 1'b0;
        set_aw(32'h1FFF, 4'h0, 8'h04);
        settle(); chk("post_err_push", 32'(push_dest_o), 32'h1); tick();
        awvalid_i = 1'b0; b_done_i = 1'b1;
        settle(); tick();
        b_done_i = 1'b0;

        // Reset while absorbing an error burst.
        set_aw(32'hF000_0000, 4'hA, 8'h00);
        settle(); chk("err2_awready", 32'(awready_o), 32'h1); tick();
        awvalid_i = 1'b0;
        settle(); tick();
        settle(); chk("wd2_he", 32'(handle_error_o), 32'h1); tick();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        settle(); chk("post_rst_he", 32'(handle_error_o), 32'h0); chk("post_rst_req", 32'(error_req_o), 32'h0);
        chk("post_rst_id", 32'(error_id_o), 32'h0); tick();
        set_aw(32'h1000, 4'h1, 8'h04);
        settle(); tick();
        settle(); tick();
        settle(); chk("post_rst_cap", 32'(awready_o), 32'h0); tick();
        awvalid_i = 1'b0; b_done_i = 1'b1;
        settle(); tick();
        settle(); tick();
        b_done_i = 1'b0;

`ifdef AXI_AW_DEC_REMAP_EN
        remap_tab[2] = 6;
        set_aw(32'h1800, 4'h0, 8'h40);
        settle(); chk("remap_awvalid", 32'(awvalid_o), 32'h40); tick();
        awvalid_i = 1'b0; b_done_i = 1'b1;
        settle(); tick();
        b_done_i = 1'b0;
        remap_tab[2] = 7; connectivity_map_i = 8'h7F;
        set_aw(32'h1800, 4'h6, 8'hFF);
        settle(); chk("remap_err_awvalid", 32'(awvalid_o), 32'h0); chk("remap_err_awready", 32'(awready_o), 32'h1); tick();
        awvalid_i = 1'b0;
        settle(); tick();
        wdata_error_completed_i = 1'b1;
        settle(); tick();
        wdata_error_completed_i = 1'b0; error_gnt_i = 1'b1;
        settle(); chk("remap_err_id", 32'(error_id_o), 32'h6); tick();
        error_gnt_i = 1'b0;
        remap_tab[2] = 2; connectivity_map_i = '1;
`endif

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) random_cfg();
            rst                     = ($urandom_range(0, 199) == 0);
            awvalid_i               = ($urandom_range(0, 3) != 0);
            awaddr_i                = pick_addr();
            awid_i                  = IW'($urandom);
            awready_i               = NP'($urandom);
            grant_fifo_dest_i       = ($urandom_range(0, 7) != 0);
            b_done_i                = !rst && (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            wdata_error_completed_i = ($urandom_range(0, 3) == 0);
            error_gnt_i             = ($urandom_range(0, 2) == 0);
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
